id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage for the 16-bit WISC pipeline. It captures the decoded instruction and the ALU controls, then presents forwarded operands, `Oper`, `invA`, `invB`, `Cin` and `sign` directly to the ALU. It resolves EX/MEM and MEM/WB data bypass, detects load-use hazards and inserts bubbles. It also honours downstream stall and flush.

## Interface
Parameters:
- OPERAND_WIDTH, 16, datapath width
- NUM_OPERATIONS, 4, width of ALU `Oper`
- REG_ADDR_W, 3, register index width (8 GPRs; R0 is an ordinary register)

Ports:
- clk  in  1  clock; the block has one clock, and every register updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid, id_uses_rs, id_uses_rt, id_use_imm, id_reg_write, id_mem_read, id_mem_write  in  1 each  decode flags
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  register indices
- id_rs_data, id_rt_data, id_imm  in  OPERAND_WIDTH each  register-file read data and sign/zero-extended immediate
- id_oper  in  NUM_OPERATIONS  ALU operation
- id_invA, id_invB, id_cin, id_sign  in  1 each  ALU controls
- exm_reg_write  in  1  bypass-source write enable (EX/MEM)
- exm_rd  in  REG_ADDR_W  bypass-source destination (EX/MEM)
- exm_result  in  OPERAND_WIDTH  bypass-source result (EX/MEM)
- mwb_reg_write  in  1  bypass-source write enable (MEM/WB)
- mwb_rd  in  REG_ADDR_W  bypass-source destination (MEM/WB)
- mwb_result  in  OPERAND_WIDTH  bypass-source result (MEM/WB)
- stall  in  1  downstream hold
- flush  in  1  squash (branch/jump redirect)
- id_stall  out  1  upstream hold; equals `stall | load_use`
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered flags
- ex_rd  out  REG_ADDR_W  registered destination
- ex_oper  out  NUM_OPERATIONS  registered ALU operation
- ex_invA, ex_invB, ex_cin, ex_sign  out  1 each  registered ALU controls
- ex_InA, ex_InB, ex_store_data  out  OPERAND_WIDTH each  forwarded ALU operands and forwarded rt data for stores

## Operation
- State: one stage register holding every id_* field, plus internal rs_q/rt_q indices and rs_data_q/rt_data_q.
- Forwarding (combinational, on register outputs), evaluated per operand with index `r`:
  - EX/MEM hit when `exm_reg_write && exm_rd==r`; MEM/WB hit when `mwb_reg_write && mwb_rd==r`.
  - EX/MEM has priority over MEM/WB; with no hit, use the stored data.
  - Forwarding applies only when `ex_valid` and the matching uses_* bit are set.
- Operand outputs:
  - ex_InA = fwdA.
  - ex_InB = use_imm_q ? imm_q : fwdB.
  - ex_store_data = fwdB, always, independent of use_imm.
- load_use = `ex_valid & ex_mem_read & ex_reg_write & id_valid & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt))`.
- Update priority per clock edge:
  1. rst: clear everything.
  2. flush: ex_valid, reg_write, mem_read and mem_write go to 0; other fields don't-care.
  3. stall: hold all fields, but reload rs_data_q←fwdA and rt_data_q←fwdB, so bypassed values survive producers leaving the pipe.
  4. load_use: insert a bubble (valid and side-effect flags go to 0; upstream is held by id_stall).
  5. otherwise: capture the id_* fields.
- A bubble or squashed entry never asserts reg_write, mem_read or mem_write.

## Timing
- Latency is 1 cycle: decode fields presented at edge N appear on ex_* after edge N.
- Reset values (asynchronous, immediate): all registered outputs are 0. ex_InA, ex_InB and ex_store_data read 0 while no bypass source matches.
- id_stall is combinational and valid in the same cycle as the inputs it depends on.
- flush during stall: flush wins, and the entry is squashed at the next edge.
- flush together with load_use: flush wins; id_stall still reflects load_use that cycle.
- rst mid-stall or mid-bubble drops the in-flight entry.
- Same-cycle hazard combinations:
  - Back-to-back dependent ALU ops need 0 stalls.
  - A load followed by a dependent op needs exactly 1 bubble.
  - A load, one independent op, then a dependent op needs 0 bubbles (MEM/WB bypass).

## Structure
- The shared package holds:
  - the Oper encodings (SLL..SUB, 4'd0–4'd15)
  - the OPERAND_WIDTH and REG_ADDR_W constants
  - a stage-payload struct typedef reused by the later pipeline registers.
- One sub-module, `operand_fwd`, instantiated twice (rs and rt): index, uses flag, stored data and both bypass sources in; forwarded data out.

## Test plan
- Reset: assert rst mid-cycle → all ex_* outputs read 0 immediately; id_stall=0.
- Dependent ADD: `ADD R1←R2+R3`, then `ADD R4←R1+R1`, with exm_rd=1 and exm_result=0x1234 → ex_InA = ex_InB = 0x1234; no stall.
- Priority: exm_rd=mwb_rd=5, exm_result=0xAAAA, mwb_result=0x5555, rs=5 → ex_InA=0xAAAA. Drop exm_reg_write → 0x5555.
- Load-use: LD R2 in EX, ADD using R2 in ID → id_stall=1 for 1 cycle, then a bubble with ex_valid=0 and reg_write=0; the ADD issues the following cycle with MEM/WB-forwarded data.
- Stall refresh: hold stall 3 cycles while the producer (result 0x00FF) passes EX/MEM, then MEM/WB, then leaves → ex_InA stays 0x00FF throughout and after release.
- Flush over stall: stall=flush=1 with a valid ST in the stage → after the edge ex_valid=0 and ex_mem_write=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared WISC pipeline constants, ALU op encodings and stage payload type
package id_ex_stage_pkg;

  localparam int OPERAND_WIDTH  = 16;
  localparam int REG_ADDR_W     = 3;
  localparam int NUM_OPERATIONS = 4;

  typedef enum logic [NUM_OPERATIONS-1:0] {
    OP_SLL  = 4'd0,
    OP_SRL  = 4'd1,
    OP_ROL  = 4'd2,
    OP_ROR  = 4'd3,
    OP_ADD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SEQ  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLE  = 4'd10,
    OP_SCO  = 4'd11,
    OP_BTR  = 4'd12,
    OP_LBI  = 4'd13,
    OP_SLBI = 4'd14,
    OP_SUB  = 4'd15
  } oper_e;

  // Common payload layout for the later pipeline registers.
  typedef struct packed {
    logic                      valid;
    logic                      uses_rs;
    logic                      uses_rt;
    logic                      use_imm;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic [REG_ADDR_W-1:0]     rs;
    logic [REG_ADDR_W-1:0]     rt;
    logic [REG_ADDR_W-1:0]     rd;
    logic [OPERAND_WIDTH-1:0]  rs_data;
    logic [OPERAND_WIDTH-1:0]  rt_data;
    logic [OPERAND_WIDTH-1:0]  imm;
    logic [NUM_OPERATIONS-1:0] oper;
    logic                      inv_a;
    logic                      inv_b;
    logic                      cin;
    logic                      sign;
  } stage_payload_t;

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// rtl/id_ex_stage_operand_fwd.sv - per-operand bypass mux: EX/MEM over MEM/WB over stored data
module operand_fwd
  import id_ex_stage_pkg::*;
#(
  parameter int W  = OPERAND_WIDTH,
  parameter int AW = REG_ADDR_W
) (
  input  logic          valid,
  input  logic          uses,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  stored,
  input  logic          exm_reg_write,
  input  logic [AW-1:0] exm_rd,
  input  logic [W-1:0]  exm_result,
  input  logic          mwb_reg_write,
  input  logic [AW-1:0] mwb_rd,
  input  logic [W-1:0]  mwb_result,
  output logic [W-1:0]  fwd
);

  logic en;
  logic exm_hit;
  logic mwb_hit;

  assign en      = valid & uses;
  assign exm_hit = en & exm_reg_write & (exm_rd == idx);
  assign mwb_hit = en & mwb_reg_write & (mwb_rd == idx);

  always_comb begin
    fwd = stored;
    if (exm_hit)      fwd = exm_result;
    else if (mwb_hit) fwd = mwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand bypass and load-use bubble insertion
module id_ex_stage #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int NUM_OPERATIONS = 4,
  parameter int REG_ADDR_W     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_use_imm,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic [REG_ADDR_W-1:0]     id_rs,
  input  logic [REG_ADDR_W-1:0]     id_rt,
  input  logic [REG_ADDR_W-1:0]     id_rd,
  input  logic [OPERAND_WIDTH-1:0]  id_rs_data,
  input  logic [OPERAND_WIDTH-1:0]  id_rt_data,
  input  logic [OPERAND_WIDTH-1:0]  id_imm,
  input  logic [NUM_OPERATIONS-1:0] id_oper,
  input  logic                      id_invA,
  input  logic                      id_invB,
  input  logic                      id_cin,
  input  logic                      id_sign,
  input  logic                      exm_reg_write,
  input  logic [REG_ADDR_W-1:0]     exm_rd,
  input  logic [OPERAND_WIDTH-1:0]  exm_result,
  input  logic                      mwb_reg_write,
  input  logic [REG_ADDR_W-1:0]     mwb_rd,
  input  logic [OPERAND_WIDTH-1:0]  mwb_result,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      id_stall,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic [REG_ADDR_W-1:0]     ex_rd,
  output logic [NUM_OPERATIONS-1:0] ex_oper,
  output logic                      ex_invA,
  output logic                      ex_invB,
  output logic                      ex_cin,
  output logic                      ex_sign,
  output logic [OPERAND_WIDTH-1:0]  ex_InA,
  output logic [OPERAND_WIDTH-1:0]  ex_InB,
  output logic [OPERAND_WIDTH-1:0]  ex_store_data
);

  logic                     uses_rs_q;
  logic                     uses_rt_q;
  logic                     use_imm_q;
  logic [REG_ADDR_W-1:0]    rs_q;
  logic [REG_ADDR_W-1:0]    rt_q;
  logic [OPERAND_WIDTH-1:0] rs_data_q;
  logic [OPERAND_WIDTH-1:0] rt_data_q;
  logic [OPERAND_WIDTH-1:0] imm_q;
  logic [OPERAND_WIDTH-1:0] fwd_a;
  logic [OPERAND_WIDTH-1:0] fwd_b;
  logic                     load_use;

  operand_fwd #(.W(OPERAND_WIDTH), .AW(REG_ADDR_W)) u_fwd_rs (
    .valid         (ex_valid),
    .uses          (uses_rs_q),
    .idx           (rs_q),
    .stored        (rs_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd           (fwd_a)
  );

  operand_fwd #(.W(OPERAND_WIDTH), .AW(REG_ADDR_W)) u_fwd_rt (
    .valid         (ex_valid),
    .uses          (uses_rt_q),
    .idx           (rt_q),
    .stored        (rt_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd           (fwd_b)
  );

  // A load in EX cannot forward yet, so a dependent op in ID must wait one cycle.
  assign load_use = ex_valid & ex_mem_read & ex_reg_write & id_valid &
                    ((id_uses_rs & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)));
  assign id_stall = stall | load_use;

  assign ex_InA        = fwd_a;
  assign ex_InB        = use_imm_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rd        <= '0;
      ex_oper      <= '0;
      ex_invA      <= 1'b0;
      ex_invB      <= 1'b0;
      ex_cin       <= 1'b0;
      ex_sign      <= 1'b0;
      uses_rs_q    <= 1'b0;
      uses_rt_q    <= 1'b0;
      use_imm_q    <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (stall) begin
      // Latch bypassed values so they survive the producer draining out of the pipe.
      rs_data_q <= fwd_a;
      rt_data_q <= fwd_b;
    end else if (load_use) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_mem_write <= id_valid & id_mem_write;
      ex_rd        <= id_rd;
      ex_oper      <= id_oper;
      ex_invA      <= id_invA;
      ex_invB      <= id_invB;
      ex_cin       <= id_cin;
      ex_sign      <= id_sign;
      uses_rs_q    <= id_uses_rs;
      uses_rt_q    <= id_uses_rt;
      use_imm_q    <= id_use_imm;
      rs_q         <= id_rs;
      rt_q         <= id_rt;
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt, id_use_imm;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_oper;
  logic        id_invA, id_invB, id_cin, id_sign;
  logic        exm_reg_write, mwb_reg_write;
  logic [2:0]  exm_rd, mwb_rd;
  logic [15:0] exm_result, mwb_result;
  logic        stall, flush;
  logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_rd;
  logic [3:0]  ex_oper;
  logic        ex_invA, ex_invB, ex_cin, ex_sign;
  logic [15:0] ex_InA, ex_InB, ex_store_data;

  int tests = 0;
  int fails = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_oper(id_oper),
    .id_invA(id_invA), .id_invB(id_invB), .id_cin(id_cin), .id_sign(id_sign),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .stall(stall), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_oper(ex_oper),
    .ex_invA(ex_invA), .ex_invB(ex_invB), .ex_cin(ex_cin), .ex_sign(ex_sign),
    .ex_InA(ex_InA), .ex_InB(ex_InB), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one valid decoded instruction on the id_* inputs.
  task automatic set_id(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                        input logic ur, input logic ut, input logic ui,
                        input logic rw, input logic mr, input logic mw,
                        input logic [15:0] rsd, input logic [15:0] rtd,
                        input logic [15:0] imm, input logic [3:0] op);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = ur; id_uses_rt = ut; id_use_imm = ui;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_oper = op;
  endtask

  task automatic no_bypass();
    exm_reg_write = 1'b0; exm_rd = 3'd0; exm_result = 16'h0;
    mwb_reg_write = 1'b0; mwb_rd = 3'd0; mwb_result = 16'h0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_invA = 1'b0; id_invB = 1'b0; id_cin = 1'b0; id_sign = 1'b0;
    set_id(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 4'd0);
    id_valid = 1'b0;
    no_bypass();
    tick(); tick();
    chk("rst_valid", {15'd0, ex_valid}, 16'd0);
    chk("rst_ina", ex_InA, 16'h0000);
    rst = 1'b0;
    #1;
    chk("rst_id_stall", {15'd0, id_stall}, 16'd0);

    // ADD R1 <- R2 + R3, captured after one edge
    set_id(3'd2, 3'd3, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0003, 16'h0, OP_ADD);
    id_cin = 1'b1;
    tick();
    id_cin = 1'b0;
    chk("add1_valid", {15'd0, ex_valid}, 16'd1);
    chk("add1_rd", {13'd0, ex_rd}, 16'd1);
    chk("add1_oper", {12'd0, ex_oper}, 16'(OP_ADD));
    chk("add1_cin", {15'd0, ex_cin}, 16'd1);
    chk("add1_ina", ex_InA, 16'h0002);
    chk("add1_inb", ex_InB, 16'h0003);

    // ADD R4 <- R1 + R1, R1 bypassed from EX/MEM
    set_id(3'd1, 3'd1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hDEAD, 16'hDEAD, 16'h0, OP_ADD);
    #1;
    chk("dep_no_stall", {15'd0, id_stall}, 16'd0);
    tick();
    exm_reg_write = 1'b1; exm_rd = 3'd1; exm_result = 16'h1234;
    #1;
    chk("dep_ina", ex_InA, 16'h1234);
    chk("dep_inb", ex_InB, 16'h1234);
    chk("dep_store", ex_store_data, 16'h1234);

    // EX/MEM beats MEM/WB; immediate replaces InB but not store data
    set_id(3'd5, 3'd6, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h0042, OP_SUB);
    tick();
    exm_reg_write = 1'b1; exm_rd = 3'd5; exm_result = 16'hAAAA;
    mwb_reg_write = 1'b1; mwb_rd = 3'd5; mwb_result = 16'h5555;
    #1;
    chk("prio_exm", ex_InA, 16'hAAAA);
    chk("imm_inb", ex_InB, 16'h0042);
    chk("imm_store", ex_store_data, 16'h2222);
    exm_reg_write = 1'b0;
    #1;
    chk("prio_mwb", ex_InA, 16'h5555);
    mwb_reg_write = 1'b0;
    #1;
    chk("prio_none", ex_InA, 16'h1111);

    // uses_rs clear: a matching bypass source must be ignored
    no_bypass();
    set_id(3'd5, 3'd6, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444, 16'h0, OP_AND);
    tick();
    exm_reg_write = 1'b1; exm_rd = 3'd5; exm_result = 16'hAAAA;
    #1;
    chk("unused_rs", ex_InA, 16'h3333);

    // Load-use: LD R2 then ADD R5 <- R2 + R3
    no_bypass();
    set_id(3'd3, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h0004, OP_ADD);
    tick();
    chk("ld_mem_read", {15'd0, ex_mem_read}, 16'd1);
    set_id(3'd2, 3'd3, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0003, 16'h0, OP_ADD);
    #1;
    chk("lu_id_stall", {15'd0, id_stall}, 16'd1);
    tick();
    exm_reg_write = 1'b1; exm_rd = 3'd2; exm_result = 16'h0104;
    #1;
    chk("lu_bubble_valid", {15'd0, ex_valid}, 16'd0);
    chk("lu_bubble_rw", {15'd0, ex_reg_write}, 16'd0);
    chk("lu_released", {15'd0, id_stall}, 16'd0);
    tick();
    exm_reg_write = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd = 3'd2; mwb_result = 16'h7777;
    #1;
    chk("lu_issue_valid", {15'd0, ex_valid}, 16'd1);
    chk("lu_issue_ina", ex_InA, 16'h7777);
    chk("lu_issue_inb", ex_InB, 16'h0003);

    // LD, independent op, dependent op: MEM/WB bypass, no bubble
    no_bypass();
    set_id(3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, OP_ADD);
    tick();
    set_id(3'd6, 3'd7, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0006, 16'h0007, 16'h0, OP_XOR);
    #1;
    chk("indep_no_stall", {15'd0, id_stall}, 16'd0);
    tick();
    set_id(3'd3, 3'd4, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0, 16'h0, OP_OR);
    #1;
    chk("ld_gap_no_stall", {15'd0, id_stall}, 16'd0);
    tick();
    mwb_reg_write = 1'b1; mwb_rd = 3'd3; mwb_result = 16'h0ABC;
    #1;
    chk("ld_gap_ina", ex_InA, 16'h0ABC);

    // Stall refresh: producer of R1 drains EX/MEM -> MEM/WB -> gone during a 3-cycle stall
    no_bypass();
    set_id(3'd1, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hDEAD, 16'h0, 16'h0, OP_ADD);
    tick();
    exm_reg_write = 1'b1; exm_rd = 3'd1; exm_result = 16'h00FF;
    stall = 1'b1;
    set_id(3'd2, 3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, OP_SLL);
    #1;
    chk("st_id_stall", {15'd0, id_stall}, 16'd1);
    chk("st_c0_ina", ex_InA, 16'h00FF);
    tick();
    exm_reg_write = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd = 3'd1; mwb_result = 16'h00FF;
    #1;
    chk("st_c1_ina", ex_InA, 16'h00FF);
    tick();
    mwb_reg_write = 1'b0;
    #1;
    chk("st_c2_ina", ex_InA, 16'h00FF);
    chk("st_hold_rd", {13'd0, ex_rd}, 16'd6);
    tick();
    stall = 1'b0;
    #1;
    chk("st_release_ina", ex_InA, 16'h00FF);

    // Flush over stall with a valid store in the stage
    no_bypass();
    set_id(3'd1, 3'd2, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0002, OP_ADD);
    tick();
    chk("st_mem_write", {15'd0, ex_mem_write}, 16'd1);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("flush_valid", {15'd0, ex_valid}, 16'd0);
    chk("flush_mem_write", {15'd0, ex_mem_write}, 16'd0);

    // Flush with load-use pending: id_stall still reports it, entry squashed
    set_id(3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, OP_ADD);
    tick();
    set_id(3'd2, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, OP_ADD);
    flush = 1'b1;
    #1;
    chk("flush_lu_id_stall", {15'd0, id_stall}, 16'd1);
    tick();
    flush = 1'b0;
    chk("flush_lu_valid", {15'd0, ex_valid}, 16'd0);
    chk("flush_lu_rw", {15'd0, ex_reg_write}, 16'd0);

    // Asynchronous reset mid-cycle drops a live entry at once
    set_id(3'd4, 3'd5, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0044, 16'h0055, 16'h0, OP_SUB);
    tick();
    chk("pre_rst_valid", {15'd0, ex_valid}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {15'd0, ex_valid}, 16'd0);
    chk("arst_rw", {15'd0, ex_reg_write}, 16'd0);
    chk("arst_rd", {13'd0, ex_rd}, 16'd0);
    chk("arst_oper", {12'd0, ex_oper}, 16'd0);
    chk("arst_ina", ex_InA, 16'h0000);
    chk("arst_inb", ex_InB, 16'h0000);
    id_valid = 1'b0;
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
